// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_IDLE
   } uart_rx_state_t;

   // Bits needed for a counter that runs 0 .. max_count-1.
   function automatic int cnt_width(input int max_count);
      return (max_count > 1) ? $clog2(max_count) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the rx pin followed by a 3-sample majority vote.
module uart_rx_sync (
   input  logic sclk,
   input  logic srst,
   input  logic rx,
   output logic rxs,
   output logic vote
);

   logic       meta;
   logic [1:0] hist;

   // NOTE: non-blocking assignments make each stage capture the previous stage's old value, forming a real shift chain.
   always_ff @(posedge sclk) begin
      if (srst) begin
         meta <= 1'b1;
         rxs  <= 1'b1;
         hist <= 2'b11;
      end else begin
         meta <= rx;
         rxs  <= meta;
         hist <= {hist[0], rxs};
      end
   end

   // Window is {rxs two cycles ago, one cycle ago, now}.
   assign vote = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with configurable framing and a valid/ready holding register.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_DIV   = 16,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int MSB_FIRST = 0
) (
   input  logic                 sclk,
   input  logic                 srst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int H     = CLK_DIV / 2;
   localparam int CNT_W = cnt_width(CLK_DIV);
   localparam int BIT_W = cnt_width(DATA_BITS);

   logic                 rxs;
   logic                 vote;
   uart_rx_state_t       state;
   uart_rx_state_t       state_next;
   logic [CNT_W-1:0]     cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_err_r;
   logic                 frm_err_r;
   logic                 tick_start;
   logic                 tick_bit;
   logic                 last_data;
   logic                 last_stop;
   logic                 frm_err_now;
   logic                 sample_data;
   logic                 sample_par;
   logic                 sample_stop;
   logic                 commit;

   uart_rx_sync u_sync (
      .sclk (sclk),
      .srst (srst),
      .rx   (rx),
      .rxs  (rxs),
      .vote (vote)
   );

   // cnt is 0 on the first cycle after entering START, so H-1 lands on t0+H.
   assign tick_start  = (cnt == CNT_W'(H - 1));
   assign tick_bit    = (cnt == CNT_W'(CLK_DIV - 1));
   assign last_data   = (bit_cnt == BIT_W'(DATA_BITS - 1));
   assign last_stop   = (bit_cnt == BIT_W'(STOP_BITS - 1));
   assign frm_err_now = frm_err_r | ~vote;
   assign commit      = sample_stop & last_stop;

   always_ff @(posedge sclk) begin
      if (srst) state <= S_IDLE;
      else      state <= state_next;
   end

   // NOTE: the default assignment up front keeps every path assigned, so no latch is inferred.
   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:      if (!rxs) state_next = S_START;
         S_START:     if (tick_start) state_next = vote ? S_IDLE : S_DATA;
         S_DATA:      if (tick_bit && last_data)
                         state_next = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
         S_PARITY:    if (tick_bit) state_next = S_STOP;
         S_STOP:      if (tick_bit && last_stop)
                         state_next = frm_err_now ? S_WAIT_IDLE : S_IDLE;
         S_WAIT_IDLE: if (rxs) state_next = S_IDLE;
         default:     state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy        = (state != S_IDLE);
      sample_data = 1'b0;
      sample_par  = 1'b0;
      sample_stop = 1'b0;
      case (state)
         S_DATA:   sample_data = tick_bit;
         S_PARITY: sample_par  = tick_bit;
         S_STOP:   sample_stop = tick_bit;
         default:  ;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (srst || state == S_IDLE || state == S_WAIT_IDLE) begin
         cnt       <= '0;
         bit_cnt   <= '0;
         par_err_r <= 1'b0;
         frm_err_r <= 1'b0;
      end else if (state == S_START) begin
         cnt <= tick_start ? '0 : cnt + CNT_W'(1);
      end else begin
         cnt <= tick_bit ? '0 : cnt + CNT_W'(1);
         if (sample_data) bit_cnt <= last_data ? '0 : bit_cnt + BIT_W'(1);
         if (sample_par)  par_err_r <= ((^shreg) ^ vote) != (PARITY == PAR_ODD);
         if (sample_stop) begin
            bit_cnt   <= bit_cnt + BIT_W'(1);
            frm_err_r <= frm_err_now;
         end
      end
   end

   // NOTE: the shifter has no reset; every bit is overwritten before a frame can commit.
   always_ff @(posedge sclk) begin
      if (sample_data) begin
         if (MSB_FIRST != 0) shreg <= {shreg[DATA_BITS-2:0], vote};
         else                shreg <= {vote, shreg[DATA_BITS-1:1]};
      end
   end

   // Holding register: a new frame replaces the old one only if it has been taken.
   always_ff @(posedge sclk) begin
      if (srst) begin
         data       <= '0;
         valid      <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (commit) begin
            if (!valid || ready) begin
               data       <= shreg;
               frame_err  <= frm_err_now;
               parity_err <= (PARITY != PAR_NONE) && par_err_r;
               valid      <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Parametrised UART receiver; next-generation replacement for the fixed 8N1 receiver in the serial path. Oversamples the asynchronous `rx` line in the `sclk` domain and supports a configurable data width, parity, stop bits and bit order. Checks every frame for framing and parity errors and delivers each byte through a valid/ready holding register with overrun detection. Sits between the board RX pin and any byte consumer (FIFO, command decoder).

## Interface
- `CLK_DIV`, 16: `sclk` cycles per bit; legal range ≥ 4.
- `DATA_BITS`, 8: payload width; legal range 5–9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `MSB_FIRST`, 0: 0 = LSB transmitted first; 1 = MSB first.

Ports:
- `sclk` in 1: the single clock.
- `srst` in 1: reset; synchronous, active-high.
- `rx` in 1: asynchronous serial line; idles high.
- `data` out DATA_BITS: received payload; reset value 0.
- `valid` out 1: `data` and the error flags are valid; reset value 0.
- `ready` in 1: consumer accepts `data` on any cycle where `valid && ready`.
- `frame_err` out 1: stop bit sampled low; qualified by `valid`; reset value 0.
- `parity_err` out 1: parity mismatch; qualified by `valid`; reset value 0; always 0 when PARITY = 0.
- `overrun` out 1: one-cycle pulse when a completed frame is dropped; reset value 0.
- `busy` out 1: the FSM is outside IDLE; reset value 0.

## Operation
- **Synchroniser.** `rx` passes through 2 flops, both reset to 1. The output is `rxs`.
- **Majority filter.** Each bit value is the 2-of-3 vote of `rxs` at bit-relative counts H-2, H-1 and H, where H = CLK_DIV/2 (floor).
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: when `rxs` = 0, clear the counter and go to START.
  - START: at count H, if the vote is 1 (glitch), return to IDLE with no output. Otherwise go to DATA, with the counter restarted so that each subsequent sample falls CLK_DIV cycles later.
  - DATA: sample DATA_BITS bits. Each bit shifts into the LSB-first or MSB-first position per MSB_FIRST. Then go to PARITY if PARITY ≠ 0, else to STOP.
  - PARITY: sample one bit. `parity_err` = XOR(payload, parity bit) ≠ (PARITY == 1 ? 1 : 0).
  - STOP: sample STOP_BITS bits. `frame_err` is set if any stop sample is 0. After the last stop sample, commit the frame. If `frame_err` is set, go to WAIT_IDLE; otherwise go to IDLE.
  - WAIT_IDLE: stay until `rxs` = 1, so a break condition yields exactly one errored frame.
- **Commit rules.**
  - If `valid` = 0, or `ready` = 1 in the same cycle: load `data`, `frame_err` and `parity_err`, and set `valid` = 1.
  - If `valid` = 1 and `ready` = 0: drop the new frame, keep the old contents, and pulse `overrun`.
- `valid` clears on a `valid && ready` cycle with no simultaneous commit.
- Frames with errors are still delivered, flagged.
- `srst` mid-frame: the next cycle returns to IDLE with all outputs at their reset values. The synchroniser is also reset to 1, so a low `rx` line restarts start detection after 2 cycles.

## Timing
- t0 is the first cycle with `rxs` = 0, which is 2 cycles after `rx` falls.
- The start vote is taken at t0+H. Bit n (n = 0 for the first data bit) is voted at t0+H+(n+1)·CLK_DIV.
- N = DATA_BITS + (PARITY ≠ 0) + STOP_BITS. The last stop vote is at t0+H+N·CLK_DIV.
- `valid`/`data` are registered and appear 1 cycle after the last stop vote. `overrun` pulses in that same cycle.
- Back-to-back frames are supported, since the next start edge is detected from IDLE. Tolerated baud mismatch is roughly ±3 % at CLK_DIV = 16.
- `ready` is combinationally sampled. There is no combinational path from `ready` to any output.

## Structure
- **Package `uart_pkg`:**
  - Parity constants `PAR_NONE` = 0, `PAR_ODD` = 1, `PAR_EVEN` = 2.
  - The `uart_rx_state_t` state enum.
  - A `clog2`-based counter width function.
- **Sub-module `uart_rx_sync`:** the 2-flop synchroniser plus the 3-sample shift and majority vote. Its ports are `sclk`, `srst`, `rx`, `rxs` and `vote`.
- The counter, FSM, shifter and holding register live in `uart_rx`.

## Test plan
- **8N1 frame.** CLK_DIV = 16, 8N1, LSB-first frame of 0x9D with `ready` = 1 → `data` = 0x9D and `valid` = 1 for 1 cycle, 8+16·9+1+2 cycles after the `rx` fall. Both error flags = 0.
- **Overrun.** 8E1, `ready` held 0, frames 0xA5 then 0x3C → first frame has `data` = 0xA5, `parity_err` = 0. Second frame pulses `overrun` and leaves `data` = 0xA5. Raising `ready` clears `valid`.
- **Parity error.** 8E1, frame 0x01 sent with parity bit 0 → `valid` with `parity_err` = 1 and `data` = 0x01.
- **Break.** Stop bit 0, then `rx` held low for 40 bit times → exactly one `valid` with `frame_err` = 1. No further `valid` until `rx` returns high and a new frame is sent.
- **Glitch rejection.** 4-cycle low glitch on idle `rx` → `busy` rises, then returns to 0 after H cycles. `valid` stays 0.
- **Reset mid-frame.**
  - Assert `srst` during DATA of frame 0x55 → next cycle `busy` = 0, `valid` = 0.
  - A following 7O2, MSB-first frame 0x2A is received correctly with `data` = 0x2A.
